mole_scheduler: RTL and testbench
=================================

Name: mole_scheduler

Overview:
Consumer end of the 4-bit random-number interface in the whack-a-mole game. It samples the random value, raises one mole (one-hot over 4 holes), and waits for either the matching button hit or a timeout. It keeps hit and miss scores over a fixed number of rounds. It sits between the random generator, the debounced button inputs, and the LED/score display logic.

Parameters:
GAP_TIME, 25000000, cycles with no mole between rounds (min 1)
UP_TIME, 50000000, max cycles a mole stays up (min 1)
ROUNDS, 16, moles per game (1..255)
TIMER_W, 32, width of internal down-counter; must hold max(GAP_TIME,UP_TIME)-1

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  level; sampled in IDLE/DONE to begin a game
rnd  input  4  random value from generator; only rnd[1:0] used
buttons  input  4  debounced, synchronized, active-high per hole
mole  output  4  one-hot raised mole, 0 when none
rnd_take  output  1  one-cycle pulse on the edge rnd is sampled
score  output  8  hits this game, saturating at 255
miss  output  8  timeouts this game, saturating at 255
busy  output  1  high in GAP and UP
done  output  1  high in DONE

Behaviour:
- All outputs registered. States: IDLE, GAP, UP, DONE.
- Reset (sync, rst=1 at an edge; overrides everything including mid-game): state=IDLE, mole=0, rnd_take=0, score=0, miss=0, busy=0, done=0, round_cnt=0, timer=0, last_hole=0, btn_prev=4'b1111.
- btn_prev<=buttons every cycle (not only in UP). press = buttons & ~btn_prev. Reset value 1111 prevents a held button from counting.
- IDLE/DONE: start=1 -> score=0, miss=0, round_cnt=0, timer=GAP_TIME-1, done=0, busy=1, state GAP. start is ignored in GAP/UP.
- GAP: timer!=0 -> timer-1. Once timer==0, on the next edge:
  - h=rnd[1:0]; if h==last_hole and round_cnt!=0, h=h+1 mod 4 (no immediate repeat).
  - mole<=1<<h, last_hole<=h, rnd_take<=1 for that one cycle, timer<=UP_TIME-1, state UP.
  - Timing: mole rises exactly GAP_TIME edges after the start edge (or after the previous round ends).
- UP, per cycle:
  - Hit: press[last_hole]=1. score+1 (sat), mole<=0, end round.
  - Timeout: else if timer==0. miss+1 (sat), mole<=0, end round.
  - Otherwise: timer-1.
  - Presses on other holes are ignored. Hit and timeout in the same cycle counts as a hit.
  - The mole stays up at most UP_TIME cycles.
- End round:
  - If round_cnt==ROUNDS-1: state DONE, done=1, busy=0.
  - Otherwise: round_cnt+1, timer=GAP_TIME-1, state GAP.
- DONE: score/miss held, mole=0. start=1 begins a new game exactly as from IDLE. Keeping start high restarts immediately.
- score/miss update on the same edge mole clears.

Test Plan:
1. Params GAP_TIME=4, UP_TIME=8, ROUNDS=3; rst 2 cycles -> all outputs 0, state IDLE. Pulse start; rnd=4'b0110 -> mole=0100 exactly 4 edges after start edge, rnd_take high 1 cycle, busy=1.
2. While mole=0100, rise buttons[2] on UP cycle 3 -> next edge mole=0, score=1, miss=0; next mole appears 4 edges later.
3. No press for 8 UP cycles -> mole clears after 8th cycle, miss=1. Pressing buttons[0] in the same window leaves score unchanged.
4. rnd=4'b0010 for rounds 1 and 2 -> round 1 mole=0100, round 2 mole=1000 (repeat bumped). After round 3: done=1, busy=0, mole=0, score/miss held.
5. Hold buttons[1] high through reset release and the mole=0010 period -> no hit counted. Release and re-press -> score+1.
6. Assert rst mid-UP -> next edge mole=0, score=0, state IDLE. start held in UP has no effect; start in DONE -> score/miss clear, new game.

Source files
------------

// File: rtl/mole_scheduler.sv
// Whack-a-mole round scheduler: samples rnd, raises one-hot mole, scores hit/timeout over ROUNDS.
// Latency: all outputs registered; mole rises GAP_TIME edges after round start; no backpressure (rnd_take is a sample strobe).
module mole_scheduler #(
    parameter int GAP_TIME = 25000000,
    parameter int UP_TIME  = 50000000,
    parameter int ROUNDS   = 16,
    parameter int TIMER_W  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] rnd,
    input  logic [3:0] buttons,
    output logic [3:0] mole,
    output logic       rnd_take,
    output logic [7:0] score,
    output logic [7:0] miss,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, GAP, UP, DONE} state_t;

    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_TIME - 1);
    localparam logic [TIMER_W-1:0] UP_LOAD    = TIMER_W'(UP_TIME - 1);
    localparam logic [7:0]         LAST_ROUND = 8'(ROUNDS - 1);

    state_t             state;
    logic [7:0]         round_cnt;
    logic [TIMER_W-1:0] timer;
    logic [1:0]         last_hole;
    logic [1:0]         next_hole;
    logic [3:0]         btn_prev;
    logic [3:0]         press;
    logic               hit;
    logic               unused_rnd;

    assign unused_rnd = ^rnd[3:2];
    assign press      = buttons & ~btn_prev;
    assign hit        = press[last_hole];

    // Bump to the neighbouring hole so the same hole never comes up twice in a row.
    always_comb begin
        next_hole = rnd[1:0];
        if (rnd[1:0] == last_hole && round_cnt != 8'd0) begin
            next_hole = rnd[1:0] + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mole      <= 4'b0000;
            rnd_take  <= 1'b0;
            score     <= 8'd0;
            miss      <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            round_cnt <= 8'd0;
            timer     <= '0;
            last_hole <= 2'd0;
            btn_prev  <= 4'b1111;
        end else begin
            btn_prev <= buttons;
            rnd_take <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        score     <= 8'd0;
                        miss      <= 8'd0;
                        round_cnt <= 8'd0;
                        timer     <= GAP_LOAD;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (timer != '0) begin
                        timer <= timer - TIMER_W'(1);
                    end else begin
                        mole      <= 4'b0001 << next_hole;
                        last_hole <= next_hole;
                        rnd_take  <= 1'b1;
                        timer     <= UP_LOAD;
                        state     <= UP;
                    end
                end
                UP: begin
                    if (hit || timer == '0) begin
                        // A hit landing on the final timeout cycle still counts as a hit.
                        if (hit) begin
                            if (score != 8'hFF) score <= score + 8'd1;
                        end else begin
                            if (miss != 8'hFF) miss <= miss + 8'd1;
                        end
                        mole <= 4'b0000;
                        if (round_cnt == LAST_ROUND) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            round_cnt <= round_cnt + 8'd1;
                            timer     <= GAP_LOAD;
                            state     <= GAP;
                        end
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: directed game sequences plus randomized rounds scored by a round-level model.
module tb_mole_scheduler;

    localparam int GAP_T    = 4;
    localparam int UP_T     = 8;
    localparam int ROUNDS_T = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] rnd;
    logic [3:0] buttons;
    logic [3:0] mole;
    logic       rnd_take;
    logic [7:0] score;
    logic [7:0] miss;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    // Round-level model state
    int exp_score;
    int exp_miss;
    int round_m;
    int last_m;

    mole_scheduler #(
        .GAP_TIME(GAP_T),
        .UP_TIME (UP_T),
        .ROUNDS  (ROUNDS_T),
        .TIMER_W (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rnd     (rnd),
        .buttons (buttons),
        .mole    (mole),
        .rnd_take(rnd_take),
        .score   (score),
        .miss    (miss),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_new_game();
        exp_score = 0;
        exp_miss  = 0;
        round_m   = 0;
    endtask

    // Called just after the edge that entered GAP; returns just after the round-ending edge.
    task automatic play_round(input logic [3:0] r, input int press_at, input int wrong_at);
        int  h;
        bit  ended;
        rnd = r;
        for (int i = 1; i < GAP_T; i++) begin
            tick();
            chk("gap_mole", mole, 0);
            chk("gap_busy", busy, 1);
        end
        h = r % 4;
        if (round_m != 0 && h == last_m) h = (h + 1) % 4;
        tick();
        chk("raise_mole", mole, 1 << h);
        chk("rnd_take_pulse", rnd_take, 1);
        last_m = h;
        ended  = 0;
        for (int c = 1; c <= UP_T && !ended; c++) begin
            buttons = 4'b0000;
            if (c == press_at) buttons[h] = 1'b1;
            if (c == wrong_at) buttons[(h + 1) % 4] = 1'b1;
            tick();
            if (c == press_at) begin
                exp_score++;
                ended = 1;
            end else if (c == UP_T) begin
                exp_miss++;
                ended = 1;
            end
            if (ended) begin
                chk("mole_clear", mole, 0);
            end else begin
                chk("mole_up", mole, 1 << h);
                chk("rnd_take_low", rnd_take, 0);
            end
        end
        buttons = 4'b0000;
        chk("score", score, exp_score);
        chk("miss", miss, exp_miss);
        round_m++;
        if (round_m == ROUNDS_T) begin
            chk("done_end", done, 1);
            chk("busy_end", busy, 0);
        end else begin
            chk("done_mid", done, 0);
            chk("busy_mid", busy, 1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rnd = 4'd0; buttons = 4'd0;
        exp_score = 0; exp_miss = 0; round_m = 0; last_m = 0;

        // Reset state
        tick(); tick();
        chk("rst_mole", mole, 0);
        chk("rst_take", rnd_take, 0);
        chk("rst_score", score, 0);
        chk("rst_miss", miss, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Game 1: hit on UP cycle 3, then timeout with a wrong-hole press, then a random round
        start = 1'b1; tick(); start = 1'b0;
        model_new_game();
        chk("start_busy", busy, 1);
        chk("start_mole", mole, 0);
        play_round(4'b0110, 3, 0);
        play_round(4'($urandom), 0, 2);
        play_round(4'($urandom), $urandom_range(0, UP_T + 1), $urandom_range(0, UP_T));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("done_hold", done, 1);
            chk("done_mole", mole, 0);
            chk("done_score", score, exp_score);
            chk("done_miss", miss, exp_miss);
        end

        // Game 2 from DONE: repeated rnd gets bumped to the next hole
        start = 1'b1; tick(); start = 1'b0;
        model_new_game();
        chk("restart_score", score, 0);
        chk("restart_miss", miss, 0);
        chk("restart_done", done, 0);
        play_round(4'b0110, 2, 0);
        play_round(4'b0010, 0, 0);
        play_round(4'($urandom), $urandom_range(0, UP_T + 1), 0);

        // Button held through reset release must not count until released and re-pressed
        buttons = 4'b0010;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        chk("rst2_score", score, 0);
        start = 1'b1; tick(); start = 1'b0;
        model_new_game();
        rnd = 4'b0001;
        repeat (GAP_T) tick();
        chk("held_raise", mole, 4'b0010);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("held_no_hit", mole, 4'b0010);
        end
        buttons = 4'b0000;
        tick();
        chk("released_up", mole, 4'b0010);
        buttons = 4'b0010;
        tick();
        buttons = 4'b0000;
        chk("repress_clear", mole, 0);
        chk("repress_score", score, 1);
        exp_score = 1; round_m = 1; last_m = 1;
        play_round(4'b0001, $urandom_range(0, UP_T + 1), 0);
        play_round(4'($urandom), $urandom_range(0, UP_T + 1), 0);

        // start held high: ignored in GAP/UP, immediate restart from DONE
        start = 1'b1; tick();
        model_new_game();
        for (int r = 0; r < ROUNDS_T; r++) begin
            play_round(4'($urandom), $urandom_range(0, UP_T + 1), $urandom_range(0, UP_T));
        end
        tick();
        model_new_game();
        chk("held_restart_done", done, 0);
        chk("held_restart_busy", busy, 1);
        chk("held_restart_score", score, 0);
        play_round(4'($urandom), 2, 0);
        start = 1'b0;

        // Reset in the middle of UP
        rnd = 4'($urandom);
        repeat (GAP_T) tick();
        chk("pre_rst_up", (mole != 4'b0000) ? 1 : 0, 1);
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_mole", mole, 0);
        chk("midrst_score", score, 0);
        chk("midrst_miss", miss, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        repeat (3) tick();
        chk("midrst_idle", busy, 0);

        // Randomized games
        for (int g = 0; g < 6; g++) begin
            start = 1'b1; tick(); start = 1'b0;
            model_new_game();
            for (int r = 0; r < ROUNDS_T; r++) begin
                play_round(4'($urandom), $urandom_range(0, UP_T + 2), $urandom_range(0, UP_T));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
